spi_master_gen: RTL

- Next-generation SPI master for peripheral access, such as the DS1302 RTC, EEPROM and ADC, from a single system clock.
- Generalises the fixed 8-bit single-device master in four ways:
  - parametrised word width;
  - runtime CPOL/CPHA selection;
  - MSB/LSB-first ordering;
  - N chip selects with multi-word bursts, where CS stays asserted between words.
- Sits between a command sequencer (RTC/flash controller FSM) and the pads.

---
 rtl/spi_gen_pkg.sv | 27 ++
 rtl/spi_master_gen_tick.sv | 25 ++
 rtl/spi_master_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_gen_pkg.sv
// Shared types and elaboration helpers for the generic SPI master.
package spi_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK,
        WAIT,
        DESEL
    } spi_state_e;

    // System clocks per SCLK half period (integer division).
    function automatic int half_period(input logic [27:0] sys_clk, input logic [27:0] spi_sclk);
        return int'(sys_clk) / (2 * int'(spi_sclk));
    endfunction

    function automatic int cnt_width(input int h);
        return $clog2(h + 1);
    endfunction

    function automatic int edge_width(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_master_gen_tick.sv
// Half-period timer: one-cycle tick every H enabled cycles, cleared while disabled.
module spi_half_tick #(
    parameter int H     = 2,
    parameter int CNT_W = 2
) (
    input  logic spi_clk,
    input  logic spi_rst,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge spi_clk) begin
        if (spi_rst || !en)
            cnt <= '0;
        else if (cnt == CNT_W'(H - 1))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == CNT_W'(H - 1));

endmodule

// File: rtl/spi_master_gen.sv
// Generic SPI master: runtime CPOL/CPHA, selectable bit order, N chip selects
// with multi-word bursts that keep CS asserted between words.
module spi_master_gen
    import spi_gen_pkg::*;
#(
    parameter logic [27:0] SYS_CLK   = 28'd50_000_000,
    parameter logic [27:0] SPI_SCLK  = 28'd100_000,
    parameter int          DATA_W    = 8,
    parameter int          CS_NUM    = 1,
    parameter logic        CS_ACTIVE = 1'b1,
    parameter logic        LSB_FIRST = 1'b0
) (
    input  logic                                        spi_clk,
    input  logic                                        spi_rst,
    input  logic                                        spi_cpol,
    input  logic                                        spi_cpha,
    input  logic [((CS_NUM > 1) ? $clog2(CS_NUM) : 1)-1:0] spi_cs_sel,
    input  logic                                        spi_wr_en,
    input  logic                                        spi_last,
    input  logic [DATA_W-1:0]                           spi_data_in,
    output logic [DATA_W-1:0]                           spi_data_out,
    output logic                                        spi_wr_ack,
    output logic                                        spi_busy,
    output logic [CS_NUM-1:0]                           spi_cs,
    output logic                                        spi_sclk,
    output logic                                        spi_mosi,
    input  logic                                        spi_miso
);

    localparam int H      = half_period(SYS_CLK, SPI_SCLK);
    localparam int CNT_W  = cnt_width(H);
    localparam int EDGE_W = edge_width(DATA_W);
    localparam int SEL_W  = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;

    if (H < 2) begin : g_h_check
        $error("spi_master_gen: SYS_CLK/(2*SPI_SCLK) must be at least 2");
    end

    spi_state_e         state;
    logic               cpol_q;
    logic               cpha_q;
    logic               last_q;
    logic [DATA_W-1:0]  shreg;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [EDGE_W-1:0]  edge_n;
    logic               last_edge;
    logic               sample_edge;
    logic               tick;
    logic               tick_en;

    assign tick_en     = (state == SETUP) || (state == SHIFT) || (state == HOLD) || (state == DESEL);
    assign edge_n      = edge_cnt + 1'b1;
    assign last_edge   = (edge_n == EDGE_W'(2 * DATA_W));
    // Odd edges sample in CPHA0, even edges sample in CPHA1.
    assign sample_edge = (edge_n[0] != cpha_q);

    spi_half_tick #(
        .H     (H),
        .CNT_W (CNT_W)
    ) u_tick (
        .spi_clk (spi_clk),
        .spi_rst (spi_rst),
        .en      (tick_en),
        .tick    (tick)
    );

    function automatic logic out_bit(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
        logic [DATA_W-1:0] r;
        if (LSB_FIRST) begin
            r = v >> 1;
            r[DATA_W-1] = b;
        end else begin
            r = v << 1;
            r[0] = b;
        end
        return r;
    endfunction

    // Out-of-range selects decode to no active CS; the frame still runs.
    function automatic logic [CS_NUM-1:0] cs_decode(input logic [SEL_W-1:0] s);
        logic [CS_NUM-1:0] r;
        for (int i = 0; i < CS_NUM; i++)
            r[i] = (int'(s) == i) ? CS_ACTIVE : ~CS_ACTIVE;
        return r;
    endfunction

    always_ff @(posedge spi_clk) begin
        if (spi_rst) begin
            state        <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            last_q       <= 1'b0;
            shreg        <= '0;
            edge_cnt     <= '0;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            spi_cs       <= {CS_NUM{~CS_ACTIVE}};
            spi_wr_ack   <= 1'b0;
            spi_busy     <= 1'b0;
            spi_data_out <= '0;
        end else begin
            spi_wr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (spi_wr_en) begin
                        cpol_q   <= spi_cpol;
                        cpha_q   <= spi_cpha;
                        last_q   <= spi_last;
                        shreg    <= spi_data_in;
                        spi_mosi <= out_bit(spi_data_in);
                        spi_sclk <= spi_cpol;
                        spi_cs   <= cs_decode(spi_cs_sel);
                        spi_busy <= 1'b1;
                        edge_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                WAIT: begin
                    // Mode and select stay as latched for the whole burst.
                    if (spi_wr_en) begin
                        last_q   <= spi_last;
                        shreg    <= spi_data_in;
                        spi_mosi <= out_bit(spi_data_in);
                        spi_busy <= 1'b1;
                        edge_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (tick) begin
                        spi_sclk <= ~spi_sclk;
                        edge_cnt <= edge_n;
                        if (sample_edge)
                            shreg <= shift_in(shreg, spi_miso);
                        else if (!last_edge)
                            spi_mosi <= out_bit(shreg);
                        if (last_edge)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        spi_data_out <= shreg;
                        spi_wr_ack   <= 1'b1;
                        state        <= ACK;
                    end
                end
                ACK: begin
                    spi_sclk <= cpol_q;
                    if (last_q) begin
                        spi_cs <= {CS_NUM{~CS_ACTIVE}};
                        state  <= DESEL;
                    end else begin
                        spi_busy <= 1'b0;
                        state    <= WAIT;
                    end
                end
                DESEL: begin
                    if (tick) begin
                        spi_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
